// File: rtl/board_scanner_if.sv
// Scan handshake and board-memory read port shared by board_scanner and its
// clients. The scanner side uses the master modport, game_FSM/memory uses slave.
interface board_scanner_if #(
   parameter int ADDR_W = 4
) ();
   logic              start;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_data;
   logic              busy;
   logic              done;
   logic              win;
   logic              full;
   logic [1:0]        winner;

   modport master (
      input  start, rd_data,
      output rd_en, rd_addr, busy, done, win, full, winner
   );

   modport slave (
      output start, rd_data,
      input  rd_en, rd_addr, busy, done, win, full, winner
   );
endinterface

// File: rtl/board_scanner.sv
// Reads the 3x3 board through one read port into a shadow copy, then decodes
// the 8 win lines and the board-full condition for game_FSM.
module board_scanner #(
   parameter int CELLS  = 9,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   board_scanner_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT_LAST,
      EVAL,
      DONE
   } state_t;

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(CELLS);

   state_t            state;
   logic [ADDR_W:0]   cnt;
   logic              rd_en_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              busy_q;
   logic              done_q;
   logic              win_q;
   logic              full_q;
   logic [1:0]        winner_q;

   logic              vld_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [1:0]        shadow_p0 [CELLS];

   logic              win_nxt;
   logic              full_nxt;
   logic [1:0]        winner_nxt;
   logic [15:0]       owners;

   // 11 is an illegal code and counts as empty for every decision.
   function automatic logic is_mark(input logic [1:0] c);
      return (c == 2'b01) || (c == 2'b10);
   endfunction

   function automatic logic [1:0] line_owner(input logic [1:0] a,
                                             input logic [1:0] b,
                                             input logic [1:0] c);
      if (is_mark(a) && (a == b) && (b == c))
         return a;
      return 2'b00;
   endfunction

   // Lowest-numbered winning line decides, so an illegal two-winner board
   // still yields a single deterministic owner.
   function automatic logic [1:0] first_owner(input logic [15:0] own);
      logic [1:0] w;
      w = 2'b00;
      for (int l = 0; l < 8; l++) begin
         if (w == 2'b00)
            w = own[2*l +: 2];
      end
      return w;
   endfunction

   always_comb begin
      owners     = '0;
      owners[1:0]   = line_owner(shadow_p0[0], shadow_p0[1], shadow_p0[2]);
      owners[3:2]   = line_owner(shadow_p0[3], shadow_p0[4], shadow_p0[5]);
      owners[5:4]   = line_owner(shadow_p0[6], shadow_p0[7], shadow_p0[8]);
      owners[7:6]   = line_owner(shadow_p0[0], shadow_p0[3], shadow_p0[6]);
      owners[9:8]   = line_owner(shadow_p0[1], shadow_p0[4], shadow_p0[7]);
      owners[11:10] = line_owner(shadow_p0[2], shadow_p0[5], shadow_p0[8]);
      owners[13:12] = line_owner(shadow_p0[0], shadow_p0[4], shadow_p0[8]);
      owners[15:14] = line_owner(shadow_p0[2], shadow_p0[4], shadow_p0[6]);
      winner_nxt = first_owner(owners);
      win_nxt    = (winner_nxt != 2'b00);
      full_nxt   = 1'b1;
      for (int i = 0; i < CELLS; i++) begin
         if (!is_mark(shadow_p0[i]))
            full_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         win_q     <= 1'b0;
         full_q    <= 1'b0;
         winner_q  <= 2'b00;
         vld_p0    <= 1'b0;
         addr_p0   <= '0;
         for (int i = 0; i < CELLS; i++)
            shadow_p0[i] <= 2'b00;
      end else begin
         // Capture stage: read data arrives one cycle after its address.
         vld_p0  <= rd_en_q;
         addr_p0 <= rd_addr_q;
         if (vld_p0)
            shadow_p0[addr_p0] <= bus.rd_data;

         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= READ;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
                  cnt       <= (ADDR_W+1)'(1);
                  busy_q    <= 1'b1;
               end
            end
            READ: begin
               if (cnt == LAST_CNT) begin
                  rd_en_q   <= 1'b0;
                  rd_addr_q <= '0;
                  state     <= WAIT_LAST;
               end else begin
                  rd_addr_q <= cnt[ADDR_W-1:0];
                  cnt       <= cnt + 1'b1;
               end
            end
            WAIT_LAST: state <= EVAL;
            EVAL: begin
               win_q    <= win_nxt;
               full_q   <= full_nxt;
               winner_q <= winner_nxt;
               done_q   <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               busy_q <= 1'b0;
               cnt    <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.win     = win_q;
   assign bus.full    = full_q;
   assign bus.winner  = winner_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: a 1-cycle-latency board memory model feeds
// the read port and each step checks cycle-exact outputs against hand values.
module tb_board_scanner;
   localparam int CELLS  = 9;
   localparam int ADDR_W = 4;

   // Boards are written in reading order: cell 0 is the leftmost pair.
   localparam logic [17:0] B_EMPTY   = '0;
   localparam logic [17:0] B_ROW1    = {2'b00,2'b00,2'b00, 2'b10,2'b10,2'b10, 2'b00,2'b00,2'b00};
   localparam logic [17:0] B_DRAW    = {2'b01,2'b10,2'b01, 2'b01,2'b10,2'b10, 2'b10,2'b01,2'b01};
   localparam logic [17:0] B_R0R2    = {2'b01,2'b01,2'b01, 2'b00,2'b00,2'b00, 2'b10,2'b10,2'b10};
   localparam logic [17:0] B_C0C2    = {2'b10,2'b00,2'b01, 2'b10,2'b00,2'b01, 2'b10,2'b00,2'b01};
   localparam logic [17:0] B_ANTI11  = {2'b00,2'b00,2'b11, 2'b00,2'b11,2'b00, 2'b11,2'b00,2'b00};
   localparam logic [17:0] B_ALL11   = {9{2'b11}};
   localparam logic [17:0] B_WINFULL = {2'b01,2'b10,2'b10, 2'b10,2'b01,2'b01, 2'b10,2'b01,2'b01};
   localparam logic [17:0] B_ANTI10  = {2'b00,2'b00,2'b10, 2'b00,2'b10,2'b00, 2'b10,2'b00,2'b00};
   localparam logic [17:0] B_ROW0    = {2'b01,2'b01,2'b01, 2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   board_scanner_if #(.ADDR_W(ADDR_W)) bus ();

   board_scanner #(.CELLS(CELLS), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [1:0] mem [16];
   logic [1:0] rd_q;
   // Idle cycles return 11 so a capture outside a read would corrupt the board.
   always @(posedge clk) rd_q <= bus.rd_en ? mem[bus.rd_addr] : 2'b11;
   assign bus.rd_data = rd_q;

   int vectors     = 0;
   int miscompares = 0;
   logic       p_win  = 1'b0;
   logic       p_full = 1'b0;
   logic [1:0] p_winner = 2'b00;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_board(input logic [17:0] b);
      for (int i = 0; i < 16; i++)
         mem[i] = (i < CELLS) ? b[17-2*i -: 2] : 2'b11;
   endtask

   task automatic check_results(input string tag, input logic w, input logic f, input logic [1:0] wn);
      check({tag, "/win"},    8'(bus.win),    8'(w));
      check({tag, "/full"},   8'(bus.full),   8'(f));
      check({tag, "/winner"}, 8'(bus.winner), 8'(wn));
   endtask

   // Full scan from IDLE: start sampled at end of cycle 0, done in cycle 12.
   task automatic scan(input string tag, input logic [17:0] b,
                       input logic w, input logic f, input logic [1:0] wn);
      load_board(b);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check({tag, "/rd_en_c1"}, 8'(bus.rd_en), 8'd1);
      check({tag, "/busy_c1"},  8'(bus.busy),  8'd1);
      repeat (10) step();
      check({tag, "/done_c11"}, 8'(bus.done), 8'd0);
      check_results({tag, "/hold_c11"}, p_win, p_full, p_winner);
      step();
      check({tag, "/done_c12"}, 8'(bus.done), 8'd1);
      check({tag, "/busy_c12"}, 8'(bus.busy), 8'd1);
      check_results({tag, "/c12"}, w, f, wn);
      step();
      check({tag, "/done_c13"}, 8'(bus.done), 8'd0);
      check({tag, "/busy_c13"}, 8'(bus.busy), 8'd0);
      p_win    = w;
      p_full   = f;
      p_winner = wn;
   endtask

   initial begin
      int dones;
      rst       = 1'b1;
      bus.start = 1'b0;
      load_board(B_EMPTY);
      step();
      step();
      check("rst/rd_en",   8'(bus.rd_en),   8'd0);
      check("rst/rd_addr", 8'(bus.rd_addr), 8'd0);
      check("rst/busy",    8'(bus.busy),    8'd0);
      check("rst/done",    8'(bus.done),    8'd0);
      check_results("rst", 1'b0, 1'b0, 2'b00);
      rst = 1'b0;
      step();

      // Empty board with cycle-exact address sequence.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < CELLS; i++) begin
         check($sformatf("t1/rd_en_%0d", i),   8'(bus.rd_en),   8'd1);
         check($sformatf("t1/rd_addr_%0d", i), 8'(bus.rd_addr), 8'(i));
         check($sformatf("t1/done_%0d", i),    8'(bus.done),    8'd0);
         step();
      end
      check("t1/rd_en_c10",   8'(bus.rd_en),   8'd0);
      check("t1/rd_addr_c10", 8'(bus.rd_addr), 8'd0);
      check("t1/busy_c10",    8'(bus.busy),    8'd1);
      step();
      check("t1/done_c11", 8'(bus.done), 8'd0);
      step();
      check("t1/done_c12", 8'(bus.done), 8'd1);
      check_results("t1", 1'b0, 1'b0, 2'b00);
      step();
      check("t1/busy_c13", 8'(bus.busy), 8'd0);
      check("t1/done_c13", 8'(bus.done), 8'd0);

      scan("row1",    B_ROW1,    1'b1, 1'b0, 2'b10);
      scan("draw",    B_DRAW,    1'b0, 1'b1, 2'b00);
      scan("r0r2",    B_R0R2,    1'b1, 1'b0, 2'b01);
      scan("c0c2",    B_C0C2,    1'b1, 1'b0, 2'b10);
      scan("anti11",  B_ANTI11,  1'b0, 1'b0, 2'b00);
      scan("all11",   B_ALL11,   1'b0, 1'b0, 2'b00);
      scan("winfull", B_WINFULL, 1'b1, 1'b1, 2'b01);
      scan("anti10",  B_ANTI10,  1'b1, 1'b0, 2'b10);

      // Starts while busy are dropped; a start in cycle 13 launches a new scan.
      load_board(B_ROW0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      dones = 0;
      for (int c = 4; c <= 12; c++) begin
         if (bus.done === 1'b1) dones++;
         if (c < 12) step();
      end
      check("t5/done_c12", 8'(bus.done), 8'd1);
      check("t5/dones",    8'(dones),    8'd1);
      check_results("t5", 1'b1, 1'b0, 2'b01);
      bus.start = 1'b1;
      step();
      check("t5/done_c13", 8'(bus.done), 8'd0);
      check("t5/busy_c13", 8'(bus.busy), 8'd0);
      step();
      bus.start = 1'b0;
      check("t5/busy_2nd",    8'(bus.busy),    8'd1);
      check("t5/rd_en_2nd",   8'(bus.rd_en),   8'd1);
      check("t5/rd_addr_2nd", 8'(bus.rd_addr), 8'd0);
      repeat (11) step();
      check("t5/done_2nd", 8'(bus.done), 8'd1);
      check_results("t5_2nd", 1'b1, 1'b0, 2'b01);
      step();
      check("t5/busy_end", 8'(bus.busy), 8'd0);

      // Reset in cycle 5 abandons the scan and clears the held results.
      load_board(B_ANTI10);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6/busy",    8'(bus.busy),    8'd0);
      check("t6/rd_en",   8'(bus.rd_en),   8'd0);
      check("t6/rd_addr", 8'(bus.rd_addr), 8'd0);
      check("t6/done",    8'(bus.done),    8'd0);
      check_results("t6", 1'b0, 1'b0, 2'b00);
      dones = 0;
      repeat (12) begin
         step();
         if (bus.done !== 1'b0) dones++;
      end
      check("t6/no_done", 8'(dones), 8'd0);
      p_win    = 1'b0;
      p_full   = 1'b0;
      p_winner = 2'b00;
      scan("t6_after", B_ANTI10, 1'b1, 1'b0, 2'b10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
